// File: rtl/video_rx_checker.sv
// video_rx_checker: measures line/frame geometry of received video, counts frames, reports lock; optional CRC-24 via VIDEO_RX_CHECKSUM_EN
module video_rx_checker #(
    parameter int HDISP  = 160,
    parameter int VDISP  = 90,
    parameter int LOCK_N = 2
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst,
    input  logic        hs_n,
    input  logic        vs_n,
    input  logic        blank,
    input  logic [23:0] rgb,
    output logic [11:0] meas_h,
    output logic [11:0] meas_v,
    output logic [15:0] frame_cnt,
    output logic        frame_done,
    output logic        h_err,
    output logic        v_err,
    output logic        locked,
    output logic [23:0] checksum
);
    localparam logic [0:0] WAIT_VS  = 1'b0;
    localparam logic [0:0] IN_FRAME = 1'b1;
    localparam int LW = $clog2(LOCK_N + 1);

    logic          hs_q, vs_q, vs_prev_q, blank_q, blank_prev_q;
    logic [0:0]    state_q, state_d;
    logic [11:0]   h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, v_line;
    logic [11:0]   meas_h_q, meas_h_d, meas_v_q, meas_v_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          acc_q, acc_d, acc_line;
    logic          done_q, h_err_q, h_err_d, v_err_q, v_err_d;
    logic [LW-1:0] good_q, good_d;
    logic          vs_fall, blank_fall, blank_rise, latch, v_bad;

    assign vs_fall    = vs_prev_q & ~vs_q;
    assign blank_fall = blank_prev_q & ~blank_q;
    assign blank_rise = ~blank_prev_q & blank_q;
    assign latch      = vs_fall & (state_q == IN_FRAME);

    // Close any line ending this cycle first so a frame end in the same cycle includes it
    always_comb begin
        v_line      = blank_fall ? ((v_cnt_q == 12'hFFF) ? v_cnt_q : v_cnt_q + 12'd1) : v_cnt_q;
        acc_line    = acc_q | (blank_fall & (h_cnt_q != 12'(HDISP)));
        v_bad       = v_line != 12'(VDISP);
        h_cnt_d     = blank_fall ? 12'd0 : (blank_q && h_cnt_q != 12'hFFF) ? h_cnt_q + 12'd1 : h_cnt_q;
        v_cnt_d     = vs_fall ? 12'd0 : v_line;
        acc_d       = (vs_fall ? 1'b0 : acc_line) | (blank_rise & ~hs_q);
        meas_h_d    = blank_fall ? h_cnt_q : meas_h_q;
        meas_v_d    = latch ? v_line : meas_v_q;
        h_err_d     = latch ? acc_line : h_err_q;
        v_err_d     = latch ? v_bad : v_err_q;
        frame_cnt_d = latch ? frame_cnt_q + 16'd1 : frame_cnt_q;
        good_d      = !latch ? good_q : (acc_line | v_bad) ? '0 :
                      (good_q == LW'(LOCK_N)) ? good_q : good_q + 1'b1;
        state_d     = vs_fall ? IN_FRAME : state_q;
    end

    // Input sampling, edge history and all frame-measurement state
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            vs_prev_q    <= 1'b1;
            blank_q      <= 1'b0;
            blank_prev_q <= 1'b0;
            state_q      <= WAIT_VS;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            acc_q        <= 1'b0;
            meas_h_q     <= '0;
            meas_v_q     <= '0;
            h_err_q      <= 1'b0;
            v_err_q      <= 1'b0;
            frame_cnt_q  <= '0;
            done_q       <= 1'b0;
            good_q       <= '0;
        end else begin
            hs_q         <= hs_n;
            vs_q         <= vs_n;
            vs_prev_q    <= vs_q;
            blank_q      <= blank;
            blank_prev_q <= blank_q;
            state_q      <= state_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            acc_q        <= acc_d;
            meas_h_q     <= meas_h_d;
            meas_v_q     <= meas_v_d;
            h_err_q      <= h_err_d;
            v_err_q      <= v_err_d;
            frame_cnt_q  <= frame_cnt_d;
            done_q       <= latch;
            good_q       <= good_d;
        end
    end

    assign meas_h     = meas_h_q;
    assign meas_v     = meas_v_q;
    assign frame_cnt  = frame_cnt_q;
    assign frame_done = done_q;
    assign h_err      = h_err_q;
    assign v_err      = v_err_q;
    assign locked     = good_q == LW'(LOCK_N);

`ifdef VIDEO_RX_CHECKSUM_EN
    localparam logic [23:0] POLY = 24'h864CFB;
    localparam logic [23:0] INIT = 24'hB704CE;

    logic [23:0] rgb_q, crc_q, crc_base, crc_d, checksum_q;

    function automatic logic [23:0] crc24(input logic [23:0] c, input logic [23:0] d);
        logic [23:0] r;
        r = c;
        for (int i = 23; i >= 0; i--)
            r = {r[22:0], 1'b0} ^ ((r[23] ^ d[i]) ? POLY : 24'h0);
        return r;
    endfunction

    assign crc_base = vs_fall ? INIT : crc_q;
    assign crc_d    = blank_q ? crc24(crc_base, rgb_q) : crc_base;

    // Pixel data sampling and per-frame CRC; a pixel in the frame-start cycle belongs to the new frame
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            rgb_q      <= '0;
            crc_q      <= '0;
            checksum_q <= '0;
        end else begin
            rgb_q      <= rgb;
            crc_q      <= crc_d;
            checksum_q <= latch ? crc_q : checksum_q;
        end
    end

    assign checksum = checksum_q;
`else
    logic unused_rgb;
    assign unused_rgb = ^rgb;
    assign checksum   = 24'h0;
`endif
endmodule
